// File: rtl/instr_issue_pkg.sv
// Shared decode definitions for the issue stage: instruction layout, opcode
// classes and the bubble encoding driven towards reg_file when nothing issues.
package instr_issue_pkg;
  localparam int OPC_W     = 4;
  localparam int OPC_LSB   = 12;
  localparam int ADDRC_LSB = 8;
  localparam int ADDRA_LSB = 4;
  localparam int ADDRB_LSB = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_RR0 = 4'h0, OP_RR1, OP_RR2, OP_RR3, OP_RR4, OP_RR5,
    OP_RA6, OP_RA7, OP_RA8, OP_RR9, OP_LOADI, OP_RAB, OP_RAC,
    OP_SETMASK, OP_NOP, OP_BUBBLE
  } opcode_e;

  localparam logic [OPC_W-1:0] BUBBLE = OP_BUBBLE;

  function automatic logic reads_a(input opcode_e op);
    case (op)
      OP_LOADI, OP_SETMASK, OP_NOP, OP_BUBBLE: reads_a = 1'b0;
      default:                                 reads_a = 1'b1;
    endcase
  endfunction

  function automatic logic reads_b(input opcode_e op);
    case (op)
      OP_RR0, OP_RR1, OP_RR2, OP_RR3, OP_RR4, OP_RR5, OP_RR9: reads_b = 1'b1;
      default:                                               reads_b = 1'b0;
    endcase
  endfunction

  function automatic logic writes_c(input opcode_e op);
    case (op)
      OP_SETMASK, OP_NOP, OP_BUBBLE: writes_c = 1'b0;
      default:                       writes_c = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/instr_issue_scoreboard.sv
// In-flight write tracker: a dependent read may issue once the producing write
// is EX_LAT cycles past its issue, so only EX_LAT-1 entries are ever live.
module hazard_scoreboard
  import instr_issue_pkg::*;
#(
  parameter int EX_LAT     = 3,
  parameter int WIDTH_ADDR = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [WIDTH_ADDR-1:0] push_addr,
  input  logic                  chk_a_en,
  input  logic [WIDTH_ADDR-1:0] chk_a,
  input  logic                  chk_b_en,
  input  logic [WIDTH_ADDR-1:0] chk_b,
  output logic                  hit
);
  localparam int DEPTH = EX_LAT - 1;

  generate
    if (DEPTH == 0) begin : g_none
      logic unused_inputs;
      assign unused_inputs = ^{clk, rstn, push, push_addr, chk_a_en, chk_a, chk_b_en, chk_b};
      assign hit = 1'b0;
    end else begin : g_sb
      logic [DEPTH-1:0]      vld;
      logic [WIDTH_ADDR-1:0] addr [DEPTH];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld <= '0;
          for (int i = 0; i < DEPTH; i++) addr[i] <= '0;
        end else begin
          vld[0]  <= push;
          addr[0] <= push_addr;
          for (int i = 1; i < DEPTH; i++) begin
            vld[i]  <= vld[i-1];
            addr[i] <= addr[i-1];
          end
        end
      end

      always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (vld[i] && ((chk_a_en && addr[i] == chk_a) || (chk_b_en && addr[i] == chk_b)))
            hit = 1'b1;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/instr_issue.sv
// Decode/issue stage in front of reg_file: splits instruction words, stalls on
// RAW and FIFO hazards, and drives bubbles so the RF never pops spuriously.
module instr_issue
  import instr_issue_pkg::*;
#(
  parameter int WIDTH_ADDR   = 4,
  parameter int WIDTH_VECTOR = 8,
  parameter int WIDTH_OPCODE = 4,
  parameter int EX_LAT       = 3,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [15:0]             in_instr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    fifo_empty,
  output logic [WIDTH_OPCODE-1:0] opcode,
  output logic [WIDTH_ADDR-1:0]   addra,
  output logic [WIDTH_ADDR-1:0]   addrb,
  output logic                    ex_valid,
  output logic [WIDTH_OPCODE-1:0] ex_opcode,
  output logic [WIDTH_ADDR-1:0]   ex_addrc,
  output logic [WIDTH_VECTOR-1:0] ex_wec,
  output logic [CNT_W-1:0]        stall_raw,
  output logic [CNT_W-1:0]        stall_fifo
);
  opcode_e                 dec_op;
  logic [WIDTH_ADDR-1:0]   dec_a, dec_b, dec_c;
  logic                    rd_a, rd_b, dec_wr, uses_fifo;
  logic                    raw_hazard, fifo_block, issue;
  logic                    fifo_last;
  logic [WIDTH_VECTOR-1:0] lane_mask;

  assign dec_op = opcode_e'(in_instr[OPC_LSB +: OPC_W]);
  assign dec_c  = in_instr[ADDRC_LSB +: WIDTH_ADDR];
  assign dec_a  = in_instr[ADDRA_LSB +: WIDTH_ADDR];
  assign dec_b  = in_instr[ADDRB_LSB +: WIDTH_ADDR];

  assign rd_a      = reads_a(dec_op);
  assign rd_b      = reads_b(dec_op);
  assign dec_wr    = writes_c(dec_op) && (dec_c != '0);
  assign uses_fifo = (rd_a && dec_a == '0) || (rd_b && dec_b == '0);

  // Back-to-back FIFO readers are spaced one cycle so fifo_empty reflects the pop.
  assign fifo_block = uses_fifo && (fifo_empty || fifo_last);
  assign in_ready   = !raw_hazard && !fifo_block;
  assign issue      = in_valid && in_ready;

  hazard_scoreboard #(
    .EX_LAT    (EX_LAT),
    .WIDTH_ADDR(WIDTH_ADDR)
  ) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .push     (issue && dec_wr),
    .push_addr(dec_c),
    .chk_a_en (rd_a && dec_a != '0),
    .chk_a    (dec_a),
    .chk_b_en (rd_b && dec_b != '0),
    .chk_b    (dec_b),
    .hit      (raw_hazard)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      opcode     <= WIDTH_OPCODE'(BUBBLE);
      addra      <= '1;
      addrb      <= '1;
      ex_valid   <= 1'b0;
      ex_opcode  <= WIDTH_OPCODE'(BUBBLE);
      ex_addrc   <= '0;
      ex_wec     <= '0;
      lane_mask  <= '1;
      fifo_last  <= 1'b0;
      stall_raw  <= '0;
      stall_fifo <= '0;
    end else begin
      fifo_last <= issue && uses_fifo;
      if (issue) begin
        opcode    <= WIDTH_OPCODE'(dec_op);
        addra     <= dec_a;
        addrb     <= dec_b;
        ex_valid  <= 1'b1;
        ex_opcode <= WIDTH_OPCODE'(dec_op);
        ex_addrc  <= dec_c;
        ex_wec    <= dec_wr ? lane_mask : '0;
        if (dec_op == OP_SETMASK) lane_mask <= in_instr[WIDTH_VECTOR-1:0];
      end else begin
        opcode    <= WIDTH_OPCODE'(BUBBLE);
        addra     <= '1;
        addrb     <= '1;
        ex_valid  <= 1'b0;
        ex_opcode <= WIDTH_OPCODE'(BUBBLE);
        ex_addrc  <= '0;
        ex_wec    <= '0;
      end
      if (in_valid && raw_hazard && stall_raw != '1)
        stall_raw <= stall_raw + CNT_W'(1);
      if (in_valid && fifo_block && !raw_hazard && stall_fifo != '1)
        stall_fifo <= stall_fifo + CNT_W'(1);
    end
  end
endmodule
